param_alu_core: RTL and testbench
=================================

PARAM_ALU_CORE -- requirements
Module: param_alu_core

Interface
REQ-001 Parameter DATA_W, default 16: width of memory words, operands and results.
REQ-002 Parameter ADDR_W, default 6: width of the memory address and of each instruction operand field.
REQ-003 Parameter PROG_LEN, default 2**ADDR_W: number of instructions executed per run, from address 0.
REQ-004 Legality: DATA_W >= 4+2*ADDR_W and 1 <= PROG_LEN <= 2**ADDR_W; elaboration SHALL fail otherwise.
REQ-005 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-006 i_rst  in  1  synchronous, active-high reset.
REQ-007 i_start  in  1  one-cycle request to begin a run while idle.
REQ-008 i_memData  in  DATA_W  read data, valid in any cycle where i_memAck=1 for a read.
REQ-009 i_memAck  in  1  memory completes the current request in this cycle.
REQ-010 o_memReq  out  1  request active.
REQ-011 o_memWrEnable  out  1  1 = write request, 0 = read request.
REQ-012 o_memAddr  out  ADDR_W  request address.
REQ-013 o_memData  out  DATA_W  write data.
REQ-014 o_busy  out  1  run in progress.
REQ-015 o_done  out  1  one-cycle pulse when a run completes.
REQ-016 o_flags  out  2  {carry, zero} of the last written result.
REQ-017 o_pc  out  ADDR_W  address of the current instruction.

Function
REQ-018 Instruction format: [DATA_W-1:DATA_W-4] opcode, [2*ADDR_W-1:ADDR_W] field A (operand 1 and destination), [ADDR_W-1:0] field B (operand-2 address, or immediate when opcode MSB=1); remaining middle bits are ignored.
REQ-019 Opcode low 3 bits: 0 ADD, 1 SUB, 2 SRA, 3 SRL, 4 SLL, 5 AND, 6 OR, 7 XOR. Immediate forms zero-extend field B to DATA_W.
REQ-020 States: IDLE, FETCH, RD1, RD2, WB. IDLE->FETCH on i_start; FETCH->RD1, RD1->RD2 (register form) or RD1->WB (immediate form), RD2->WB; each transition taken only on a cycle with i_memAck=1.
REQ-021 Transactions: FETCH reads o_pc; RD1 reads field A; RD2 reads field B; WB writes the result to field A.
REQ-022 o_memReq=1 in FETCH/RD1/RD2/WB, 0 in IDLE. o_memWrEnable=1 only in WB. o_memAddr and o_memData are held stable while o_memReq=1 and i_memAck=0. In non-WB states o_memData=0.
REQ-023 i_memAck while o_memReq=0 is ignored. With i_memAck held high: 4 cycles per register-form instruction, 3 per immediate-form instruction.
REQ-024 Arithmetic modulo 2**DATA_W. Shift amount = full operand-2 value; SRL/SLL with amount >= DATA_W give 0; SRA with amount >= DATA_W gives all copies of the operand-1 sign bit.
REQ-025 On the WB ack: zero = (result==0); carry = ADD carry-out, SUB borrow (operand1 < operand2 unsigned), 0 for all other ops.
REQ-026 On the WB ack: if o_pc == PROG_LEN-1, go to IDLE, pulse o_done for one cycle and set o_pc to 0; otherwise increment o_pc and go to FETCH.
REQ-027 o_busy=1 in every state except IDLE. i_start is ignored while busy.
REQ-028 i_start in the same cycle as the final WB ack does not chain a new run; the core spends at least one cycle in IDLE.

Reset
REQ-029 At the first clock edge with i_rst=1: state IDLE, o_pc=0, o_flags=0, o_done=0, o_busy=0, o_memReq=0, o_memWrEnable=0, o_memAddr=0, o_memData=0, internal instruction/operand registers 0.
REQ-030 Reset overrides i_start and i_memAck. If reset is asserted mid-WB with i_memAck=0 in that cycle, no write is issued and the destination is unchanged.

Verification (DATA_W=16, ADDR_W=6, PROG_LEN=1 unless stated; i_memAck=1 unless stated)
REQ-031 mem[0]=0x0289 (ADD A=10 B=9), mem[10]=0x0003, mem[9]=0x0005, i_start pulse -> mem[10]=0x0008, o_flags=00, o_done pulses 4 cycles after the first request.
REQ-032 mem[0]=0x8281 (ADDi A=10 imm 1), mem[10]=0xFFFF -> mem[10]=0x0000, o_flags=11 (carry, zero), 3 request cycles.
REQ-033 mem[0]=0xA294 (SRAi imm 20), mem[10]=0x8000 -> 0xFFFF; same test with 0xB294 (SRLi) -> 0x0000, zero=1.
REQ-034 ADD test of REQ-031 with i_memAck low for 3 cycles in each state -> o_memAddr and o_memData stable while waiting, same result, 16 cycles total.
REQ-035 PROG_LEN=2, two-instruction program -> o_pc sequence 0,1,0; a single o_done pulse; i_start during the run is ignored.
REQ-036 i_rst asserted during a WB wait (i_memAck=0) -> o_memReq=0 after the edge, mem[10] unchanged, o_busy=0.

Source files
------------

// File: rtl/param_alu_core.sv
// ---------------------------------------------------------------------------
// param_alu_core
//
// Small memory-based ALU sequencer. After a start pulse it executes PROG_LEN
// instructions stored at addresses 0..PROG_LEN-1 of an external single-port
// memory. Each instruction goes through FETCH, RD1 (operand 1), an optional
// RD2 (operand 2, register form only) and WB (write result back to field A).
// Every phase holds its memory request until the memory acknowledges it.
//
// Instruction word:
//   [DATA_W-1:DATA_W-4]  opcode (bit 3 = immediate form, bits 2:0 = operation)
//   [2*ADDR_W-1:ADDR_W]  field A: operand-1 address and destination
//   [ADDR_W-1:0]         field B: operand-2 address, or zero-extended immediate
//
// Ports:
//   i_clk          clock, everything changes on its rising edge
//   i_rst          synchronous active-high reset
//   i_start        one-cycle request to begin a run (ignored while busy)
//   i_memData      read data, valid when i_memAck is high for a read
//   i_memAck       memory completes the current request this cycle
//   o_memReq       request active
//   o_memWrEnable  1 = write request, 0 = read request
//   o_memAddr      request address
//   o_memData      write data (0 outside of write-back)
//   o_busy         run in progress
//   o_done         one-cycle pulse when a run completes
//   o_flags        {carry, zero} of the last written result
//   o_pc           address of the current instruction
// ---------------------------------------------------------------------------
module param_alu_core #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 6,
  parameter int PROG_LEN = 2**ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_memData,
  input  logic              i_memAck,
  output logic              o_memReq,
  output logic              o_memWrEnable,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [DATA_W-1:0] o_memData,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_flags,
  output logic [ADDR_W-1:0] o_pc
);

  // Refuse to build configurations where the instruction fields cannot fit
  // in a data word or the program does not fit in the address space.
  generate
    if (DATA_W < 4 + 2*ADDR_W) begin : g_badWidth
      $error("param_alu_core: DATA_W must be at least 4+2*ADDR_W");
    end
    if (PROG_LEN < 1 || PROG_LEN > 2**ADDR_W) begin : g_badProgLen
      $error("param_alu_core: PROG_LEN must lie in 1..2**ADDR_W");
    end
  endgenerate

  localparam logic [ADDR_W-1:0] LAST_PC     = ADDR_W'(PROG_LEN - 1);
  localparam logic [DATA_W-1:0] SHIFT_LIMIT = DATA_W'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_RD1,
    S_RD2,
    S_WB
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic [1:0]        r_flags;
  logic              r_done;

  logic [3:0]        w_opcode;
  logic [ADDR_W-1:0] w_fieldA;
  logic [ADDR_W-1:0] w_fieldB;
  logic              w_isImm;
  logic              w_lastInstr;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic              w_shiftBig;
  logic [DATA_W-1:0] w_result;
  logic              w_carry;

  assign w_opcode    = r_instr[DATA_W-1:DATA_W-4];
  assign w_fieldA    = r_instr[2*ADDR_W-1:ADDR_W];
  assign w_fieldB    = r_instr[ADDR_W-1:0];
  assign w_isImm     = w_opcode[3];
  assign w_lastInstr = (r_pc == LAST_PC);

  // Extra top bit of the sum is the carry-out; for the difference it is set
  // exactly when operand 1 < operand 2 unsigned, i.e. the borrow.
  assign w_sum      = {1'b0, r_op1} + {1'b0, r_op2};
  assign w_diff     = {1'b0, r_op1} - {1'b0, r_op2};
  assign w_shiftBig = (r_op2 >= SHIFT_LIMIT);

  // ALU: operands are captured registers, so the result is stable for the
  // whole write-back phase however long the memory takes to acknowledge.
  always_comb begin
    w_result = '0;
    w_carry  = 1'b0;
    case (w_opcode[2:0])
      3'd0: begin
        w_result = w_sum[DATA_W-1:0];
        w_carry  = w_sum[DATA_W];
      end
      3'd1: begin
        w_result = w_diff[DATA_W-1:0];
        w_carry  = w_diff[DATA_W];
      end
      3'd2: begin
        if (w_shiftBig) begin
          w_result = {DATA_W{r_op1[DATA_W-1]}};
        end else begin
          w_result = $unsigned($signed(r_op1) >>> r_op2);
        end
      end
      3'd3: w_result = w_shiftBig ? '0 : (r_op1 >> r_op2);
      3'd4: w_result = w_shiftBig ? '0 : (r_op1 << r_op2);
      3'd5: w_result = r_op1 & r_op2;
      3'd6: w_result = r_op1 | r_op2;
      3'd7: w_result = r_op1 ^ r_op2;
      default: w_result = '0;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and memory-interface outputs. Address and write data are
  // derived only from registers that change on an acknowledge, so they hold
  // steady while a request waits.
  always_comb begin
    w_nextState   = r_state;
    o_memReq      = 1'b1;
    o_memWrEnable = 1'b0;
    o_memAddr     = '0;
    o_memData     = '0;
    case (r_state)
      S_IDLE: begin
        o_memReq = 1'b0;
        if (i_start) w_nextState = S_FETCH;
      end
      S_FETCH: begin
        o_memAddr = r_pc;
        if (i_memAck) w_nextState = S_RD1;
      end
      S_RD1: begin
        o_memAddr = w_fieldA;
        if (i_memAck) w_nextState = w_isImm ? S_WB : S_RD2;
      end
      S_RD2: begin
        o_memAddr = w_fieldB;
        if (i_memAck) w_nextState = S_WB;
      end
      S_WB: begin
        o_memWrEnable = 1'b1;
        o_memAddr     = w_fieldA;
        o_memData     = w_result;
        if (i_memAck) w_nextState = w_lastInstr ? S_IDLE : S_FETCH;
      end
      default: begin
        o_memReq    = 1'b0;
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Datapath: capture the instruction and operands on their acknowledges,
  // and on the write-back acknowledge update flags and advance (or wrap) the
  // program counter. The done pulse lands in the first idle cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc    <= '0;
      r_instr <= '0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (i_memAck) r_instr <= i_memData;
        end
        S_RD1: begin
          if (i_memAck) begin
            r_op1 <= i_memData;
            if (w_isImm) r_op2 <= {{(DATA_W-ADDR_W){1'b0}}, w_fieldB};
          end
        end
        S_RD2: begin
          if (i_memAck) r_op2 <= i_memData;
        end
        S_WB: begin
          if (i_memAck) begin
            r_flags <= {w_carry, (w_result == '0)};
            if (w_lastInstr) begin
              r_pc   <= '0;
              r_done <= 1'b1;
            end else begin
              r_pc <= r_pc + ADDR_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = r_done;
  assign o_flags = r_flags;
  assign o_pc    = r_pc;

endmodule

// File: tb/tb_param_alu_core.sv
// ---------------------------------------------------------------------------
// tb_param_alu_core
//
// Drives param_alu_core against a behavioural memory with three acknowledge
// styles (always, random, three-cycle wait per request) and compares the
// final memory image, flags, cycle count and pc trace against an
// instruction-level reference model of the programme.
// ---------------------------------------------------------------------------
module tb_param_alu_core;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 6;
  localparam int PROG_LEN  = 4;
  localparam int MEM_WORDS = 2**ADDR_W;

  logic              i_clk;
  logic              i_rst;
  logic              i_start;
  logic [DATA_W-1:0] i_memData = '0;
  logic              i_memAck  = 1'b0;
  logic              o_memReq;
  logic              o_memWrEnable;
  logic [ADDR_W-1:0] o_memAddr;
  logic [DATA_W-1:0] o_memData;
  logic              o_busy;
  logic              o_done;
  logic [1:0]        o_flags;
  logic [ADDR_W-1:0] o_pc;

  logic [DATA_W-1:0] mem    [MEM_WORDS];
  logic [DATA_W-1:0] expMem [MEM_WORDS];

  int checkCount = 0;
  int passCount  = 0;
  int ackMode    = 0;
  int waitCnt    = 0;
  int writesSeen = 0;
  bit holdValid  = 1'b0;
  logic [ADDR_W-1:0] holdAddr = '0;
  logic [DATA_W-1:0] holdData = '0;

  param_alu_core #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .PROG_LEN(PROG_LEN)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_memData    (i_memData),
    .i_memAck     (i_memAck),
    .o_memReq     (o_memReq),
    .o_memWrEnable(o_memWrEnable),
    .o_memAddr    (o_memAddr),
    .o_memData    (o_memData),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_flags      (o_flags),
    .o_pc         (o_pc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", tag, actual, expected);
  endtask

  // Behavioural memory. Acknowledge and read data change on the falling
  // edge; writes are committed just before the rising edge that accepts them.
  // While a request waits, its address and write data must not move.
  always begin
    @(negedge i_clk);
    if (holdValid) begin
      checkOutput("holdAddr", 32'(o_memAddr), 32'(holdAddr));
      checkOutput("holdData", 32'(o_memData), 32'(holdData));
    end
    case (ackMode)
      0:       i_memAck = 1'b1;
      1:       i_memAck = ($urandom_range(0, 1) == 1);
      default: i_memAck = o_memReq && (waitCnt == 3);
    endcase
    i_memData = mem[o_memAddr];
    #4;
    if (o_memReq && i_memAck && o_memWrEnable) begin
      mem[o_memAddr] = o_memData;
      writesSeen++;
    end
    holdValid = o_memReq && !i_memAck && !i_rst;
    holdAddr  = o_memAddr;
    holdData  = o_memData;
    if (o_memReq && !i_memAck) waitCnt++;
    else waitCnt = 0;
  end

  // Instruction-level reference: executes the programme on expMem with plain
  // integer arithmetic and returns the number of memory transactions.
  task automatic modelRun(output int trans, output logic [1:0] flags);
    int unsigned ins, opc, a, b, x, y, r;
    int s;
    bit c;
    trans = 0;
    flags = 2'b00;
    for (int pc = 0; pc < PROG_LEN; pc++) begin
      ins = 32'(expMem[pc]);
      opc = ins >> 12;
      a   = (ins >> 6) & 63;
      b   = ins & 63;
      x   = 32'(expMem[a]);
      y   = (opc >= 8) ? b : 32'(expMem[b]);
      c   = 1'b0;
      r   = 0;
      case (opc % 8)
        0: begin r = x + y; c = (r > 65535); end
        1: begin c = (x < y); r = x + 65536 - y; end
        2: begin
          if (y >= 16) begin
            if (x >= 32768) r = 65535;
            else r = 0;
          end else begin
            if (x >= 32768) s = int'(x) - 65536;
            else s = int'(x);
            s = s >>> y;
            r = s;
          end
        end
        3: if (y >= 16) r = 0; else r = x >> y;
        4: if (y >= 16) r = 0; else r = x << y;
        5: r = x & y;
        6: r = x | y;
        7: r = x ^ y;
        default: r = 0;
      endcase
      r = r & 32'hFFFF;
      expMem[a] = 16'(r);
      flags = {c, (r == 0)};
      trans += (opc >= 8) ? 3 : 4;
    end
  endtask

  function automatic logic [DATA_W-1:0] randWord();
    case ($urandom_range(0, 5))
      0:       return 16'($urandom_range(0, 20));
      1:       return 16'h0000;
      2:       return 16'hFFFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic randomProgram();
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = randWord();
    for (int pc = 0; pc < PROG_LEN; pc++)
      mem[pc] = {4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)),
                 6'($urandom_range(0, 63))};
  endtask

  // Clears memory and fills slots 0..2 with ORi #0 on scratch words 50..52 so
  // the instruction under test at slot 3 determines the final flags.
  task automatic fillerProgram();
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = '0;
    for (int k = 0; k < 3; k++) mem[k] = 16'hE000 | 16'((50 + k) << 6);
  endtask

  // Runs the programme in memory, with stray start pulses during the run and
  // a start coincident with the final write-back acknowledge.
  task automatic applyStimulus(input int mode, output int reqCycles);
    int expTrans, doneSeen, finished;
    logic [1:0] expFlags;
    int pcSeq[$];
    expMem = mem;
    modelRun(expTrans, expFlags);
    ackMode    = mode;
    writesSeen = 0;
    reqCycles  = 0;
    doneSeen   = 0;
    finished   = 0;
    @(negedge i_clk); #1;
    i_start = 1'b1;
    @(negedge i_clk); #1;
    i_start = 1'b0;
    pcSeq.push_back(int'(o_pc));
    for (int cyc = 0; cyc < 4000 && finished == 0; cyc++) begin
      if (int'(o_pc) != pcSeq[$]) pcSeq.push_back(int'(o_pc));
      if (o_done) begin
        finished = 1;
        doneSeen++;
      end else begin
        if (o_memReq) reqCycles++;
        checkOutput("busyInRun", 32'(o_busy), 32'd1);
        if (o_memReq && !o_memWrEnable) checkOutput("readData0", 32'(o_memData), 32'd0);
        i_start = (o_memWrEnable && i_memAck && int'(o_pc) == PROG_LEN - 1) ||
                  ($urandom_range(0, 7) == 0);
        @(negedge i_clk); #1;
      end
    end
    i_start = 1'b0;
    checkOutput("runFinished", 32'(finished), 32'd1);
    checkOutput("busyAtDone", 32'(o_busy), 32'd0);
    checkOutput("reqAtDone", 32'(o_memReq), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk); #1;
      checkOutput("idleAfterDone", 32'(o_memReq), 32'd0);
      checkOutput("donePulseLen", 32'(o_done), 32'd0);
    end
    checkOutput("doneCount", 32'(doneSeen), 32'd1);
    checkOutput("pcSeqLen", 32'(pcSeq.size()), 32'(PROG_LEN + 1));
    for (int i = 0; i <= PROG_LEN && i < pcSeq.size(); i++)
      checkOutput("pcSeq", 32'(pcSeq[i]), (i == PROG_LEN) ? 32'd0 : 32'(i));
    checkOutput("writeCount", 32'(writesSeen), 32'(PROG_LEN));
    checkOutput("flags", 32'(o_flags), 32'(expFlags));
    for (int i = 0; i < MEM_WORDS; i++)
      checkOutput($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(expMem[i]));
    if (mode == 0) checkOutput("cyclesAckHigh", 32'(reqCycles), 32'(expTrans));
    if (mode == 2) checkOutput("cyclesWait3", 32'(reqCycles), 32'(expTrans * 4));
  endtask

  int cycles;
  int found;
  int dest;
  logic [DATA_W-1:0] oldVal;

  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = '0;
    repeat (3) @(negedge i_clk);
    #1;
    checkOutput("rstReq", 32'(o_memReq), 32'd0);
    checkOutput("rstWrEn", 32'(o_memWrEnable), 32'd0);
    checkOutput("rstAddr", 32'(o_memAddr), 32'd0);
    checkOutput("rstData", 32'(o_memData), 32'd0);
    checkOutput("rstBusy", 32'(o_busy), 32'd0);
    checkOutput("rstDone", 32'(o_done), 32'd0);
    checkOutput("rstFlags", 32'(o_flags), 32'd0);
    checkOutput("rstPc", 32'(o_pc), 32'd0);
    i_rst = 1'b0;

    // ADD A=10 B=9: 3 + 5.
    fillerProgram();
    mem[3] = 16'h0289; mem[10] = 16'h0003; mem[9] = 16'h0005;
    applyStimulus(0, cycles);
    checkOutput("addResult", 32'(mem[10]), 32'h0008);
    checkOutput("addFlags", 32'(o_flags), 32'b00);
    checkOutput("addCycles", 32'(cycles), 32'd13);

    // ADDi A=10 #1 on 0xFFFF: wraps to zero with carry.
    fillerProgram();
    mem[3] = 16'h8281; mem[10] = 16'hFFFF;
    applyStimulus(0, cycles);
    checkOutput("addiResult", 32'(mem[10]), 32'h0000);
    checkOutput("addiFlags", 32'(o_flags), 32'b11);
    checkOutput("addiCycles", 32'(cycles), 32'd12);

    // SRAi #20 on a negative word fills with the sign bit.
    fillerProgram();
    mem[3] = 16'hA294; mem[10] = 16'h8000;
    applyStimulus(0, cycles);
    checkOutput("sraBigResult", 32'(mem[10]), 32'hFFFF);
    checkOutput("sraBigFlags", 32'(o_flags), 32'b00);

    // SRLi #20 on the same word clears it.
    fillerProgram();
    mem[3] = 16'hB294; mem[10] = 16'h8000;
    applyStimulus(0, cycles);
    checkOutput("srlBigResult", 32'(mem[10]), 32'h0000);
    checkOutput("srlBigFlags", 32'(o_flags), 32'b01);

    // ADD again with every request waiting three cycles.
    fillerProgram();
    mem[3] = 16'h0289; mem[10] = 16'h0003; mem[9] = 16'h0005;
    applyStimulus(2, cycles);
    checkOutput("addWaitResult", 32'(mem[10]), 32'h0008);
    checkOutput("addWaitCycles", 32'(cycles), 32'd52);

    // Random programmes under all acknowledge styles.
    for (int t = 0; t < 24; t++) begin
      randomProgram();
      applyStimulus(t % 3, cycles);
    end

    // Reset while the first write-back is waiting for its acknowledge.
    fillerProgram();
    ackMode = 2;
    @(negedge i_clk); #1;
    i_start = 1'b1;
    @(negedge i_clk); #1;
    i_start = 1'b0;
    found = 0;
    dest  = 0;
    oldVal = '0;
    for (int cyc = 0; cyc < 200 && found == 0; cyc++) begin
      if (o_memReq && o_memWrEnable && !i_memAck) begin
        found  = 1;
        dest   = int'(o_memAddr);
        oldVal = mem[o_memAddr];
        i_rst  = 1'b1;
      end
      @(negedge i_clk); #1;
    end
    checkOutput("rstWbFound", 32'(found), 32'd1);
    checkOutput("rstWbReq", 32'(o_memReq), 32'd0);
    checkOutput("rstWbBusy", 32'(o_busy), 32'd0);
    checkOutput("rstWbPc", 32'(o_pc), 32'd0);
    checkOutput("rstWbFlags", 32'(o_flags), 32'd0);
    i_rst = 1'b0;
    repeat (5) @(negedge i_clk);
    #1;
    checkOutput("rstWbDest", 32'(mem[dest]), 32'(oldVal));
    checkOutput("rstWbStayIdle", 32'(o_busy), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
